led_matrix_scan_ctrl: RTL and testbench

- Scan controller for the 8x8 LED matrix. Holds a double-buffered frame (front bank displayed, back bank written by a host) and sequences the row/column drive with a blanking interval before every row to suppress ghosting.
- Swaps banks only at a frame boundary, so the display never tears.
- row/col feed the anode pins and the cathode TBUF enables in top.

---
 rtl/led_matrix_pkg.sv | 16 +
 rtl/led_matrix_scan_ctrl_if.sv | 32 +++
 rtl/led_frame_bank.sv | 41 ++++
 rtl/led_matrix_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared types for the 8x8 LED matrix scan controller
package led_matrix_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [COLS-1:0] row_t;
   typedef row_t [ROWS-1:0] frame_t;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_t;

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// rtl/led_matrix_scan_ctrl_if.sv - host write and bank swap handshake
interface led_matrix_scan_ctrl_if;
   import led_matrix_pkg::*;

   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_row;
   row_t       wr_data;
   logic       swap_req;
   logic       swap_ack;

   // Host side: issues row writes and swap requests
   modport master (
      output wr_valid,
      output wr_row,
      output wr_data,
      output swap_req,
      input  wr_ready,
      input  swap_ack
   );

   // Controller side
   modport slave (
      input  wr_valid,
      input  wr_row,
      input  wr_data,
      input  swap_req,
      output wr_ready,
      output swap_ack
   );

endinterface

// File: rtl/led_frame_bank.sv
// rtl/led_frame_bank.sv - double-buffered 8x8 frame store with front/back select
module led_frame_bank
   import led_matrix_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  row_t       wr_data,
   input  logic       toggle,
   input  logic [2:0] rd_row,
   output row_t       rd_data,
   output logic       front_sel
);

   frame_t bank [2];
   logic   back_sel;

   assign back_sel = ~front_sel;
   assign rd_data  = bank[front_sel][rd_row];

   // Host writes always land in the bank that is not on display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank[0] <= '0;
         bank[1] <= '0;
      end else if (wr_en) begin
         bank[back_sel][wr_row] <= wr_data;
      end
   end

   // Front bank selector flips once per committed swap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         front_sel <= 1'b0;
      end else if (toggle) begin
         front_sel <= back_sel;
      end
   end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// rtl/led_matrix_scan_ctrl.sv - row scan sequencer with blanking and tear-free bank swap
module led_matrix_scan_ctrl
   import led_matrix_pkg::*;
#(
   parameter int ROW_TICKS   = 27000,
   parameter int BLANK_TICKS = 270
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   led_matrix_scan_ctrl_if.slave  host,
   output logic                   frame_start,
   output row_t                   row,
   output row_t                   col
);

   localparam int CW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(ROW_TICKS - BLANK_TICKS - 1);

   scan_state_t   state;
   logic [CW-1:0] tick;
   logic [2:0]    row_idx;
   logic          swap_pending;
   logic          swap_ack_q;
   logic          wr_en;
   logic          row_end;
   logic          wrap;
   logic          commit;
   logic          front_sel;
   row_t          front_row;

   // Writes stall while a swap is waiting so nothing lands in a bank about to go live
   assign host.wr_ready = ~swap_pending;
   assign host.swap_ack = swap_ack_q;
   assign wr_en         = host.wr_valid & ~swap_pending;

   assign row_end = (state == DRIVE) && enable && (tick == DRIVE_LAST);
   assign wrap    = row_end && (row_idx == 3'd7);
   assign commit  = swap_pending && ((state == IDLE) || wrap);

   led_frame_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_row    (host.wr_row),
      .wr_data   (host.wr_data),
      .toggle    (commit),
      .rd_row    (row_idx),
      .rd_data   (front_row),
      .front_sel (front_sel)
   );

   // Scan FSM, tick counter, swap tracking and registered drive outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tick         <= '0;
         row_idx      <= '0;
         swap_pending <= 1'b0;
         swap_ack_q   <= 1'b0;
         frame_start  <= 1'b0;
         row          <= '0;
         col          <= '0;
      end else begin
         frame_start <= 1'b0;
         swap_ack_q  <= commit;
         if (commit) begin
            swap_pending <= 1'b0;
         end else if (host.swap_req) begin
            swap_pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (enable) begin
                  state       <= BLANK;
                  tick        <= '0;
                  row_idx     <= '0;
                  frame_start <= 1'b1;
               end
            end
            BLANK: begin
               if (!enable) begin
                  state   <= IDLE;
                  tick    <= '0;
                  row_idx <= '0;
               end else if (tick == BLANK_LAST) begin
                  state <= DRIVE;
                  tick  <= '0;
                  row   <= row_t'(1) << row_idx;
                  col   <= front_row;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            DRIVE: begin
               if (!enable) begin
                  state   <= IDLE;
                  tick    <= '0;
                  row_idx <= '0;
                  row     <= '0;
                  col     <= '0;
               end else if (row_end) begin
                  state       <= BLANK;
                  tick        <= '0;
                  row_idx     <= row_idx + 3'd1;
                  row         <= '0;
                  col         <= '0;
                  frame_start <= wrap;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tick  <= '0;
               row   <= '0;
               col   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// tb/tb_led_matrix_scan_ctrl.sv - directed bench for led_matrix_scan_ctrl
module tb_led_matrix_scan_ctrl;
   import led_matrix_pkg::*;

   logic clk;
   logic rst_n;
   logic enable;
   logic frame_start;
   row_t row;
   row_t col;
   int   n_vec;
   int   n_err;
   int   cyc;
   row_t pat [8];

   led_matrix_scan_ctrl_if bus ();

   led_matrix_scan_ctrl #(.ROW_TICKS(10), .BLANK_TICKS(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .host        (bus),
      .frame_start (frame_start),
      .row         (row),
      .col         (col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic start_scan();
      enable = 0; bus.wr_valid = 0; bus.swap_req = 0; bus.wr_row = 0; bus.wr_data = 0;
      rst_n = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      enable = 1;
      step();
      cyc = 1;
   endtask

   task automatic write_row(input logic [2:0] r, input row_t d);
      bus.wr_valid = 1; bus.wr_row = r; bus.wr_data = d;
      step();
      bus.wr_valid = 0;
   endtask

   task automatic pulse_swap();
      bus.swap_req = 1;
      step();
      bus.swap_req = 0;
   endtask

   task automatic test_reset();
      enable = 0; bus.wr_valid = 0; bus.swap_req = 0; bus.wr_row = 0; bus.wr_data = 0;
      rst_n = 0;
      @(negedge clk); @(negedge clk);
      n_vec++; if (row !== 8'h00) begin n_err++; $display("FAIL reset_row: got %h want 00", row); end
      n_vec++; if (col !== 8'h00) begin n_err++; $display("FAIL reset_col: got %h want 00", col); end
      n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
      n_vec++; if (bus.swap_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", bus.swap_ack); end
      n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
      rst_n = 1;
      repeat (3) @(negedge clk);
      n_vec++; if (row !== 8'h00 || frame_start !== 1'b0) begin n_err++; $display("FAIL idle_quiet: got row %h fs %b want 00 0", row, frame_start); end
   endtask

   task automatic test_scan();
      int p, r;
      row_t exp_row;
      logic exp_fs;
      start_scan();
      for (int k = 1; k <= 81; k++) begin
         p = (k - 1) % 10;
         r = ((k - 1) / 10) % 8;
         exp_row = (p < 2) ? 8'h00 : (8'h01 << r);
         exp_fs  = ((k - 1) % 80) == 0;
         n_vec++; if (row !== exp_row) begin n_err++; $display("FAIL scan_row c%0d: got %h want %h", k, row, exp_row); end
         n_vec++; if (frame_start !== exp_fs) begin n_err++; $display("FAIL scan_fs c%0d: got %b want %b", k, frame_start, exp_fs); end
         n_vec++; if (col !== 8'h00) begin n_err++; $display("FAIL scan_col c%0d: got %h want 00", k, col); end
         if (k < 81) step();
      end
   endtask

   task automatic test_swap();
      int bad_ready, bad_col, p, r;
      row_t exp_col;
      start_scan();
      for (int i = 0; i < 8; i++) write_row(3'(i), pat[i]);
      pulse_swap();
      bad_ready = 0; bad_col = 0;
      while (bus.swap_ack !== 1'b1 && cyc < 200) begin
         if (bus.wr_ready !== 1'b0) bad_ready++;
         if (col !== 8'h00) bad_col++;
         step();
      end
      n_vec++; if (cyc != 81) begin n_err++; $display("FAIL swap_ack_cycle: got %0d want 81", cyc); end
      n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL swap_fs_with_ack: got %b want 1", frame_start); end
      n_vec++; if (bad_ready != 0) begin n_err++; $display("FAIL swap_wr_ready_low: got %0d high cycles want 0", bad_ready); end
      n_vec++; if (bad_col != 0) begin n_err++; $display("FAIL swap_pre_frame_col: got %0d lit cycles want 0", bad_col); end
      n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL swap_ready_after: got %b want 1", bus.wr_ready); end
      bad_col = 0;
      while (cyc < 160) begin
         step();
         p = (cyc - 1) % 10;
         r = ((cyc - 1) / 10) % 8;
         exp_col = (p < 2) ? 8'h00 : pat[r];
         if (col !== exp_col) bad_col++;
         if (cyc == 83) begin
            n_vec++; if (row !== 8'h01 || col !== 8'h60) begin n_err++; $display("FAIL swap_row0: got row %h col %h want 01 60", row, col); end
         end
         if (cyc == 153) begin
            n_vec++; if (row !== 8'h80 || col !== 8'h01) begin n_err++; $display("FAIL swap_row7: got row %h col %h want 80 01", row, col); end
         end
      end
      n_vec++; if (bad_col != 0) begin n_err++; $display("FAIL swap_frame_cols: got %0d wrong cycles want 0", bad_col); end
   endtask

   task automatic test_stall();
      int bad_ready;
      start_scan();
      write_row(3'd2, 8'hAA);
      pulse_swap();
      bus.wr_valid = 1; bus.wr_row = 3'd2; bus.wr_data = 8'h55;
      bad_ready = 0;
      while (bus.swap_ack !== 1'b1 && cyc < 200) begin
         if (bus.wr_ready !== 1'b0) bad_ready++;
         step();
      end
      n_vec++; if (bad_ready != 0) begin n_err++; $display("FAIL stall_ready: got %0d high cycles want 0", bad_ready); end
      n_vec++; if (cyc != 81 || bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got cyc %0d ready %b want 81 1", cyc, bus.wr_ready); end
      step();
      bus.wr_valid = 0;
      run_to(103);
      n_vec++; if (row !== 8'h04 || col !== 8'hAA) begin n_err++; $display("FAIL stall_display: got row %h col %h want 04 aa", row, col); end
      pulse_swap();
      while (bus.swap_ack !== 1'b1 && cyc < 300) step();
      n_vec++; if (cyc != 161) begin n_err++; $display("FAIL stall_second_ack: got %0d want 161", cyc); end
      run_to(183);
      n_vec++; if (row !== 8'h04 || col !== 8'h55) begin n_err++; $display("FAIL stall_write_landed: got row %h col %h want 04 55", row, col); end
   endtask

   task automatic test_double_swap();
      int acks, ack_cyc;
      row_t col83, col163;
      start_scan();
      write_row(3'd0, 8'h0F);
      pulse_swap();
      run_to(5);
      pulse_swap();
      acks = 0; ack_cyc = 0; col83 = 'x; col163 = 'x;
      while (cyc < 170) begin
         if (bus.swap_ack === 1'b1) begin acks++; ack_cyc = cyc; end
         if (cyc == 83) col83 = col;
         if (cyc == 163) col163 = col;
         step();
      end
      n_vec++; if (acks != 1) begin n_err++; $display("FAIL dbl_ack_count: got %0d want 1", acks); end
      n_vec++; if (ack_cyc != 81) begin n_err++; $display("FAIL dbl_ack_cycle: got %0d want 81", ack_cyc); end
      n_vec++; if (col83 !== 8'h0F) begin n_err++; $display("FAIL dbl_frame1: got %h want 0f", col83); end
      n_vec++; if (col163 !== 8'h0F) begin n_err++; $display("FAIL dbl_frame2: got %h want 0f", col163); end
   endtask

   task automatic test_enable_drop();
      start_scan();
      write_row(3'd3, 8'h3C);
      write_row(3'd0, 8'h81);
      pulse_swap();
      run_to(115);
      n_vec++; if (row !== 8'h08 || col !== 8'h3C) begin n_err++; $display("FAIL drop_before: got row %h col %h want 08 3c", row, col); end
      enable = 0;
      step();
      n_vec++; if (row !== 8'h00 || col !== 8'h00) begin n_err++; $display("FAIL drop_off: got row %h col %h want 00 00", row, col); end
      repeat (3) step();
      n_vec++; if (row !== 8'h00 || frame_start !== 1'b0) begin n_err++; $display("FAIL drop_idle: got row %h fs %b want 00 0", row, frame_start); end
      enable = 1;
      step();
      n_vec++; if (frame_start !== 1'b1 || row !== 8'h00) begin n_err++; $display("FAIL drop_restart: got fs %b row %h want 1 00", frame_start, row); end
      step(); step();
      n_vec++; if (row !== 8'h01 || col !== 8'h81) begin n_err++; $display("FAIL drop_row0: got row %h col %h want 01 81", row, col); end
   endtask

   task automatic test_reset_mid();
      int acks, lit;
      start_scan();
      write_row(3'd1, 8'hFF);
      pulse_swap();
      run_to(15);
      n_vec++; if (row !== 8'h02 || bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL rmid_before: got row %h ready %b want 02 0", row, bus.wr_ready); end
      #2 rst_n = 0; enable = 0;
      #1;
      n_vec++; if (row !== 8'h00 || col !== 8'h00 || frame_start !== 1'b0 || bus.swap_ack !== 1'b0) begin
         n_err++; $display("FAIL rmid_async: got row %h col %h fs %b ack %b want 00 00 0 0", row, col, frame_start, bus.swap_ack);
      end
      n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", bus.wr_ready); end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      enable = 1;
      acks = 0; lit = 0;
      for (int i = 0; i < 170; i++) begin
         step();
         if (bus.swap_ack === 1'b1) acks++;
         if (col !== 8'h00) lit++;
      end
      n_vec++; if (acks != 0) begin n_err++; $display("FAIL rmid_no_ack: got %0d want 0", acks); end
      n_vec++; if (lit != 0) begin n_err++; $display("FAIL rmid_blank_frame: got %0d lit cycles want 0", lit); end
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      pat[0] = 8'h60; pat[1] = 8'h80; pat[2] = 8'h80; pat[3] = 8'h66;
      pat[4] = 8'h09; pat[5] = 8'h09; pat[6] = 8'h06; pat[7] = 8'h01;
      rst_n = 0; enable = 0;
      bus.wr_valid = 0; bus.swap_req = 0; bus.wr_row = 0; bus.wr_data = 0;
      test_reset();
      test_scan();
      test_swap();
      test_stall();
      test_double_swap();
      test_enable_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
